regfile_port_ctrl: RTL and testbench

//  Sequencer/arbiter in front of the BitCell-array register file. It clears all registers after reset,

---
 rtl/regfile_port_ctrl.sv | 114 +++++++++++
 tb/tb_regfile_port_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_ctrl.sv
// Write-port sequencer/arbiter for the BitCell register file: post-reset clear sweep,
// then wb/dbg arbitration with debug anti-starvation, word-line decode and bypass flags.
module regfile_port_ctrl #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_req,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_data,
  output logic                wb_gnt,
  input  logic                dbg_req,
  input  logic [ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]   dbg_data,
  output logic                dbg_gnt,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [NUM_REGS-1:0] rf_write_en,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] rf_read_en1,
  output logic [NUM_REGS-1:0] rf_read_en2,
  output logic                bypass1,
  output logic                bypass2,
  output logic                busy
);

  localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [NUM_REGS-1:0] WL_ONE     = NUM_REGS'(1);
  localparam logic [ADDR_W-1:0]   LAST_REG   = ADDR_W'(NUM_REGS - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_q, clr_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_any;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= CLEAR;
      clr_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      starve_q <= starve_d;
    end
  end

  // Next-state, arbitration and word-line decode.
  always_comb begin
    state_d       = state_q;
    clr_d         = clr_q;
    starve_d      = starve_q;
    busy          = 1'b0;
    wb_gnt        = 1'b0;
    dbg_gnt       = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    wr_any        = 1'b0;
    rf_write_en   = '0;
    rf_write_data = '0;
    bypass1       = 1'b0;
    bypass2       = 1'b0;
    rf_read_en1   = WL_ONE << rd_addr1;
    rf_read_en2   = WL_ONE << rd_addr2;

    if (!rst || state_q == CLEAR) begin
      // Clear sweep writes zero into every row, R0 included; requests are ignored.
      busy        = 1'b1;
      rf_write_en = WL_ONE << clr_q;
      if (rst) begin
        clr_d = clr_q + ADDR_W'(1);
        if (clr_q == LAST_REG) begin
          state_d = IDLE;
        end
      end
    end else begin
      dbg_gnt = dbg_req & (~wb_req | (starve_q == STARVE_MAX));
      wb_gnt  = wb_req & ~dbg_gnt;
      wr_any  = wb_gnt | dbg_gnt;
      wr_addr = dbg_gnt ? dbg_addr : wb_addr;
      wr_data = dbg_gnt ? dbg_data : wb_data;

      if (wr_any) begin
        rf_write_data = wr_data;
        // R0 is hardwired zero: the grant stands but the word-line stays low.
        if (wr_addr != '0) begin
          rf_write_en = WL_ONE << wr_addr;
        end
        bypass1 = (wr_addr == rd_addr1) && (rd_addr1 != '0);
        bypass2 = (wr_addr == rd_addr2) && (rd_addr2 != '0);
      end

      if (!dbg_req || dbg_gnt) begin
        starve_d = '0;
      end else if (wb_req && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl: driver predicts each cycle's outputs from a
// behavioural model and queues them; a negedge monitor pops and compares.
module tb_regfile_port_ctrl;

  localparam int NR  = 16;
  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_req = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_gnt;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data = '0;
  logic          dbg_gnt;
  logic [AW-1:0] rd_addr1 = '0;
  logic [AW-1:0] rd_addr2 = '0;
  logic [NR-1:0] rf_write_en;
  logic [DW-1:0] rf_write_data;
  logic [NR-1:0] rf_read_en1;
  logic [NR-1:0] rf_read_en2;
  logic          bypass1;
  logic          bypass2;
  logic          busy;

  always #5 clk = ~clk;

  regfile_port_ctrl #(
    .NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_gnt(dbg_gnt),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rf_write_en(rf_write_en), .rf_write_data(rf_write_data),
    .rf_read_en1(rf_read_en1), .rf_read_en2(rf_read_en2),
    .bypass1(bypass1), .bypass2(bypass2), .busy(busy)
  );

  typedef struct {
    logic          busy;
    logic          wg;
    logic          dg;
    logic          b1;
    logic          b2;
    logic [NR-1:0] wen;
    logic [DW-1:0] wdata;
    logic [NR-1:0] r1;
    logic [NR-1:0] r2;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   checks = 0;
  int   errors = 0;

  // Model: rows swept since the last reset edge (NR means sweep done), and debug's wait.
  int   cleared = 0;
  int   blocked = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m = sb.pop_front();
      chk("busy",    32'(busy),          32'(m.busy));
      chk("wb_gnt",  32'(wb_gnt),        32'(m.wg));
      chk("dbg_gnt", 32'(dbg_gnt),       32'(m.dg));
      chk("wr_en",   32'(rf_write_en),   32'(m.wen));
      chk("wr_data", 32'(rf_write_data), 32'(m.wdata));
      chk("rd_en1",  32'(rf_read_en1),   32'(m.r1));
      chk("rd_en2",  32'(rf_read_en2),   32'(m.r2));
      chk("bypass1", 32'(bypass1),       32'(m.b1));
      chk("bypass2", 32'(bypass2),       32'(m.b2));
    end
  end

  // Drive one cycle of inputs, queue the predicted outputs, advance the model to the next edge.
  task automatic step(input logic r, input logic wr, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic dr, input logic [AW-1:0] da,
                      input logic [DW-1:0] dd, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, output logic dg_o);
    exp_t          e;
    logic          dg;
    logic          wg;
    logic [AW-1:0] ga;
    logic [DW-1:0] gd;
    rst = r; wb_req = wr; wb_addr = wa; wb_data = wd;
    dbg_req = dr; dbg_addr = da; dbg_data = dd; rd_addr1 = a1; rd_addr2 = a2;
    e.busy = 1'b0; e.b1 = 1'b0; e.b2 = 1'b0; e.wen = '0; e.wdata = '0;
    e.r1 = NR'(1) << a1;
    e.r2 = NR'(1) << a2;
    dg = 1'b0;
    wg = 1'b0;
    if (!r || cleared < NR) begin
      e.busy = 1'b1;
      e.wen  = NR'(1) << (cleared % NR);
    end else begin
      dg = dr && (!wr || blocked == LIM);
      wg = wr && !dg;
      ga = dg ? da : wa;
      gd = dg ? dd : wd;
      if (dg || wg) begin
        e.wdata = gd;
        e.wen   = (ga == 0) ? '0 : (NR'(1) << ga);
        e.b1    = (a1 == ga) && (a1 != 0);
        e.b2    = (a2 == ga) && (a2 != 0);
      end
    end
    e.wg = wg;
    e.dg = dg;
    sb.push_back(e);
    if (!r) begin
      cleared = 0;
      blocked = 0;
    end else if (cleared < NR) begin
      cleared++;
    end else if (!dr || dg) begin
      blocked = 0;
    end else if (wr && blocked < LIM) begin
      blocked++;
    end
    dg_o = dg;
    @(posedge clk);
    #1;
  endtask

  task automatic noisy_clear(input int n);
    logic g;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
           16'($urandom), 4'($urandom), 4'($urandom), g);
    end
  endtask

  initial begin
    logic          g;
    logic          dp;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [AW-1:0] wa;
    dp = 1'b0; pa = '0; pd = '0;
    @(posedge clk);
    #1;
    repeat (3) step(1'b0, 1'b1, 4'd3, 16'h1111, 1'b1, 4'd4, 16'h2222, 4'd1, 4'd2, g);

    // Release reset: 16-row sweep with requests ignored, then idle.
    noisy_clear(NR);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, g);

    step(1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0, 4'd1, 4'd2, g);
    step(1'b1, 1'b1, 4'd0, 16'h1234, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, g);

    // Contention: wb wins LIM times, debug gets the next grant, then wb resumes.
    for (int i = 0; i < LIM + 2; i++) begin
      step(1'b1, 1'b1, 4'(i + 1), 16'(i), (i <= LIM), 4'd9, 16'hD00D, 4'd9, 4'(i + 1), g);
    end

    step(1'b1, 1'b1, 4'd5, 16'h0555, 1'b0, 4'd0, 16'h0, 4'd5, 4'd0, g);
    step(1'b1, 1'b1, 4'd0, 16'h0AAA, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, g);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h7777, 4'd0, 4'd0, g);

    // Randomised traffic with held debug requests and occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (!dp && $urandom_range(0, 3) == 0) begin
        dp = 1'b1;
        pa = 4'($urandom);
        pd = 16'($urandom);
      end
      wa = 4'($urandom);
      step(($urandom_range(0, 99) != 0), 1'($urandom), wa, 16'($urandom), dp, pa, pd,
           ($urandom_range(0, 1) == 1) ? wa : 4'($urandom),
           ($urandom_range(0, 1) == 1) ? pa : 4'($urandom), g);
      if (g) dp = 1'b0;
    end

    // Reset pulse in the middle of a sweep restarts it from row 0.
    step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, g);
    noisy_clear(7);
    step(1'b0, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd7, 16'h7777, 4'd6, 4'd7, g);
    noisy_clear(NR);
    step(1'b1, 1'b1, 4'd6, 16'h6666, 1'b0, 4'd0, 16'h0, 4'd6, 4'd7, g);
    step(1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0, g);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
